// File: rtl/alu_pipe.sv
// alu_pipe: XLEN-generic integer ALU (add/sub/slt/shift/logic, RV64 word ops)
// with valid/ready handshakes, a registered result stage backed by a
// FIFO_DP-deep result buffer, and a pipeline flush.
// Optional feature macro: ALU_PERF_CNT_EN (adds alu_perf_ops / alu_perf_stall).
module alu_pipe #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned RNBIT   = 2,
  parameter int unsigned FIFO_DP = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 flush,
  input  logic                 alu_execute_valid,
  output logic                 alu_execute_ready,
  input  logic [8:0]           alu_fun,
  input  logic                 alu_is32w,
  input  logic                 alu_isUsi,
  input  logic [5+RNBIT-1:0]   alu_rd0,
  input  logic [XLEN-1:0]      alu_op1,
  input  logic [XLEN-1:0]      alu_op2,
  output logic                 alu_writeback_valid,
  input  logic                 alu_writeback_ready,
  output logic [XLEN-1:0]      alu_writeback_res,
  output logic [5+RNBIT-1:0]   alu_writeback_rd0
`ifdef ALU_PERF_CNT_EN
  ,
  output logic [63:0]          alu_perf_ops,
  output logic [63:0]          alu_perf_stall
`endif
);

  localparam int unsigned RDW = 5 + RNBIT;
  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned PW  = $clog2(FIFO_DP);
  localparam int unsigned CW  = PW + 1;

  // One-hot function encodings {add,sub,slt,sll,srl,sra,xor,or,and}
  localparam logic [8:0] FN_ADD = 9'b1_0000_0000;
  localparam logic [8:0] FN_SUB = 9'b0_1000_0000;
  localparam logic [8:0] FN_SLT = 9'b0_0100_0000;
  localparam logic [8:0] FN_SLL = 9'b0_0010_0000;
  localparam logic [8:0] FN_SRL = 9'b0_0001_0000;
  localparam logic [8:0] FN_SRA = 9'b0_0000_1000;
  localparam logic [8:0] FN_XOR = 9'b0_0000_0100;
  localparam logic [8:0] FN_OR  = 9'b0_0000_0010;
  localparam logic [8:0] FN_AND = 9'b0_0000_0001;

  typedef struct packed {
    logic [RDW-1:0]  rd0;
    logic [XLEN-1:0] res;
  } entry_t;

  entry_t           mem [FIFO_DP];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_d;
  logic             push;
  logic             pop;

  logic             w32;
  logic [XLEN-1:0]  sum;
  logic [XLEN-1:0]  diff;
  logic [SHW-1:0]   shamt;
  logic [4:0]       shamt_w;
  logic [31:0]      sll32;
  logic [31:0]      srl32;
  logic [31:0]      sra32;
  logic             lt;
  logic [XLEN-1:0]  res_c;

  // Sign-extend a 32-bit word to XLEN
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return XLEN'($signed(x));
  endfunction

  // Combinational ALU datapath; unknown/multi-hot function codes yield 0
  always_comb begin
    w32     = (XLEN == 64) && alu_is32w;
    sum     = alu_op1 + alu_op2;
    diff    = alu_op1 + ~alu_op2 + XLEN'(1);
    shamt   = alu_op2[SHW-1:0];
    shamt_w = alu_op2[4:0];
    sll32   = alu_op1[31:0] << shamt_w;
    srl32   = alu_op1[31:0] >> shamt_w;
    sra32   = $signed(alu_op1[31:0]) >>> shamt_w;
    lt      = alu_isUsi ? (alu_op1 < alu_op2) : ($signed(alu_op1) < $signed(alu_op2));
    res_c   = '0;
    case (alu_fun)
      FN_ADD:  res_c = w32 ? sext32(sum[31:0])  : sum;
      FN_SUB:  res_c = w32 ? sext32(diff[31:0]) : diff;
      FN_SLT:  res_c = XLEN'(lt);
      FN_SLL:  res_c = w32 ? sext32(sll32) : (alu_op1 << shamt);
      FN_SRL:  res_c = w32 ? sext32(srl32) : (alu_op1 >> shamt);
      FN_SRA:  res_c = w32 ? sext32(sra32) : XLEN'($signed(alu_op1) >>> shamt);
      FN_XOR:  res_c = alu_op1 ^ alu_op2;
      FN_OR:   res_c = alu_op1 | alu_op2;
      FN_AND:  res_c = alu_op1 & alu_op2;
      default: res_c = '0;
    endcase
  end

  // Handshake decode and next occupancy
  always_comb begin
    push    = alu_execute_valid && alu_execute_ready && !flush;
    pop     = alu_writeback_valid && alu_writeback_ready;
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
  end

  // Buffer control: pointers, occupancy and registered handshake flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      alu_writeback_valid <= 1'b0;
      alu_execute_ready   <= 1'b1;
    end else if (flush) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      alu_writeback_valid <= 1'b0;
      alu_execute_ready   <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count               <= count_d;
      alu_writeback_valid <= (count_d != '0);
      alu_execute_ready   <= (count_d != CW'(FIFO_DP));
    end
  end

  // Result storage; contents are don't-care until written
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{rd0: alu_rd0, res: res_c};
  end

  assign alu_writeback_res = mem[rd_ptr].res;
  assign alu_writeback_rd0 = mem[rd_ptr].rd0;

`ifdef ALU_PERF_CNT_EN
  // Accepted-op and issue-stall counters; survive flush, cleared by reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alu_perf_ops   <= '0;
      alu_perf_stall <= '0;
    end else begin
      if (push) alu_perf_ops <= alu_perf_ops + 64'd1;
      if (alu_execute_valid && !alu_execute_ready) alu_perf_stall <= alu_perf_stall + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (XLEN=64, RNBIT=2, FIFO_DP=2).
module tb_alu_pipe;

  logic        CLK;
  logic        RST;
  logic        flush;
  logic        alu_execute_valid;
  logic        alu_execute_ready;
  logic [8:0]  alu_fun;
  logic        alu_is32w;
  logic        alu_isUsi;
  logic [6:0]  alu_rd0;
  logic [63:0] alu_op1;
  logic [63:0] alu_op2;
  logic        alu_writeback_valid;
  logic        alu_writeback_ready;
  logic [63:0] alu_writeback_res;
  logic [6:0]  alu_writeback_rd0;
`ifdef ALU_PERF_CNT_EN
  logic [63:0] alu_perf_ops;
  logic [63:0] alu_perf_stall;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [8:0] F_ADD = 9'b1_0000_0000;
  localparam logic [8:0] F_SUB = 9'b0_1000_0000;
  localparam logic [8:0] F_SLT = 9'b0_0100_0000;
  localparam logic [8:0] F_SLL = 9'b0_0010_0000;
  localparam logic [8:0] F_SRL = 9'b0_0001_0000;
  localparam logic [8:0] F_SRA = 9'b0_0000_1000;
  localparam logic [8:0] F_XOR = 9'b0_0000_0100;
  localparam logic [8:0] F_OR  = 9'b0_0000_0010;
  localparam logic [8:0] F_AND = 9'b0_0000_0001;

  alu_pipe #(.XLEN(64), .RNBIT(2), .FIFO_DP(2)) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .flush               (flush),
    .alu_execute_valid   (alu_execute_valid),
    .alu_execute_ready   (alu_execute_ready),
    .alu_fun             (alu_fun),
    .alu_is32w           (alu_is32w),
    .alu_isUsi           (alu_isUsi),
    .alu_rd0             (alu_rd0),
    .alu_op1             (alu_op1),
    .alu_op2             (alu_op2),
    .alu_writeback_valid (alu_writeback_valid),
    .alu_writeback_ready (alu_writeback_ready),
    .alu_writeback_res   (alu_writeback_res),
    .alu_writeback_rd0   (alu_writeback_rd0)
`ifdef ALU_PERF_CNT_EN
    ,
    .alu_perf_ops        (alu_perf_ops),
    .alu_perf_stall      (alu_perf_stall)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [8:0] f, input logic w, input logic usi,
                       input logic [6:0] rd, input logic [63:0] a, input logic [63:0] b);
    alu_execute_valid = 1'b1;
    alu_fun   = f;
    alu_is32w = w;
    alu_isUsi = usi;
    alu_rd0   = rd;
    alu_op1   = a;
    alu_op2   = b;
  endtask

  // Issue one op into an empty buffer and check it one cycle later
  task automatic run_op(input string tag, input logic [8:0] f, input logic w, input logic usi,
                        input logic [6:0] rd, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp);
    @(negedge CLK);
    drive(f, w, usi, rd, a, b);
    @(negedge CLK);
    alu_execute_valid = 1'b0;
    check({tag, "_valid"}, 64'(alu_writeback_valid), 64'd1);
    check({tag, "_res"}, alu_writeback_res, exp);
    check({tag, "_rd0"}, 64'(alu_writeback_rd0), 64'(rd));
  endtask

  initial begin
    CLK = 1'b0;
    RST = 1'b1;
    flush = 1'b0;
    alu_writeback_ready = 1'b1;
    drive(F_ADD, 1'b0, 1'b0, 7'd0, 64'd0, 64'd0);
    alu_execute_valid = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_valid", 64'(alu_writeback_valid), 64'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_ready", 64'(alu_execute_ready), 64'd1);
    check("post_rst_valid", 64'(alu_writeback_valid), 64'd0);

    // Arithmetic, compare, shift and logic vectors
    run_op("add32w", F_ADD, 1'b1, 1'b0, 7'h15, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000);
    run_op("add64", F_ADD, 1'b0, 1'b0, 7'h01, 64'h7FFF_FFFF, 64'd1, 64'h0000_0000_8000_0000);
    run_op("sub64", F_SUB, 1'b0, 1'b0, 7'h02, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("sub32w", F_SUB, 1'b1, 1'b0, 7'h03, 64'h1_0000_0000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("slt_s", F_SLT, 1'b0, 1'b0, 7'h04, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
    run_op("slt_u", F_SLT, 1'b1, 1'b1, 7'h05, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    run_op("sra32w", F_SRA, 1'b1, 1'b0, 7'h06, 64'h0000_0000_8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000);
    run_op("srl64", F_SRL, 1'b0, 1'b0, 7'h07, 64'h8000_0000_0000_0000, 64'd63, 64'd1);
    run_op("sra64", F_SRA, 1'b0, 1'b0, 7'h08, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000);
    run_op("srl32w", F_SRL, 1'b1, 1'b0, 7'h09, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0000_0000_0800_0000);
    run_op("srl32w_s0", F_SRL, 1'b1, 1'b0, 7'h0A, 64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000);
    run_op("sll32w", F_SLL, 1'b1, 1'b0, 7'h0B, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000);
    run_op("sll64", F_SLL, 1'b0, 1'b0, 7'h0C, 64'd1, 64'd63, 64'h8000_0000_0000_0000);
    run_op("sll64_mask", F_SLL, 1'b0, 1'b0, 7'h0D, 64'd1, 64'h41, 64'd2);
    run_op("xor", F_XOR, 1'b1, 1'b0, 7'h0E, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0);
    run_op("or", F_OR, 1'b1, 1'b0, 7'h0F, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hFFF0_FFF0_FFF0_FFF0);
    run_op("and", F_AND, 1'b0, 1'b0, 7'h10, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000);
    run_op("multihot", 9'b1_1000_0000, 1'b0, 1'b0, 7'h11, 64'd5, 64'd7, 64'd0);
    run_op("zerofun", 9'd0, 1'b0, 1'b0, 7'h12, 64'd5, 64'd7, 64'd0);
    @(negedge CLK);
    check("idle_valid", 64'(alu_writeback_valid), 64'd0);

    // Backpressure: three back-to-back ops into a 2-deep buffer
    alu_writeback_ready = 1'b0;
    drive(F_ADD, 1'b0, 1'b0, 7'd1, 64'd1, 64'd0);
    @(negedge CLK);
    check("bp_ready1", 64'(alu_execute_ready), 64'd1);
    drive(F_ADD, 1'b0, 1'b0, 7'd2, 64'd2, 64'd0);
    @(negedge CLK);
    check("bp_ready_full", 64'(alu_execute_ready), 64'd0);
    drive(F_ADD, 1'b0, 1'b0, 7'd3, 64'd3, 64'd0);
    @(negedge CLK);
    check("bp_held_ready", 64'(alu_execute_ready), 64'd0);
    check("bp_head_res", alu_writeback_res, 64'd1);
    check("bp_head_rd0", 64'(alu_writeback_rd0), 64'd1);
    alu_writeback_ready = 1'b1;
    @(negedge CLK);
    check("bp_pop1_res", alu_writeback_res, 64'd2);
    check("bp_pop1_rd0", 64'(alu_writeback_rd0), 64'd2);
    check("bp_pop1_ready", 64'(alu_execute_ready), 64'd1);
    @(negedge CLK);
    alu_execute_valid = 1'b0;
    check("bp_third_valid", 64'(alu_writeback_valid), 64'd1);
    check("bp_third_res", alu_writeback_res, 64'd3);
    check("bp_third_rd0", 64'(alu_writeback_rd0), 64'd3);
    @(negedge CLK);
    check("bp_drained", 64'(alu_writeback_valid), 64'd0);

    // Flush with one buffered op and an incoming op while ready
    alu_writeback_ready = 1'b0;
    drive(F_ADD, 1'b0, 1'b0, 7'h20, 64'd8, 64'd0);
    @(negedge CLK);
    drive(F_ADD, 1'b0, 1'b0, 7'h21, 64'd9, 64'd0);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    alu_execute_valid = 1'b0;
    check("fl1_valid", 64'(alu_writeback_valid), 64'd0);
    check("fl1_ready", 64'(alu_execute_ready), 64'd1);

    // Flush with two buffered ops and a new valid op
    drive(F_ADD, 1'b0, 1'b0, 7'h22, 64'd10, 64'd0);
    @(negedge CLK);
    drive(F_ADD, 1'b0, 1'b0, 7'h23, 64'd11, 64'd0);
    @(negedge CLK);
    drive(F_ADD, 1'b0, 1'b0, 7'h7F, 64'd12, 64'd0);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    alu_execute_valid = 1'b0;
    check("fl2_valid", 64'(alu_writeback_valid), 64'd0);
    check("fl2_ready", 64'(alu_execute_ready), 64'd1);
    alu_writeback_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("fl2_no_return", 64'(alu_writeback_valid), 64'd0);
    end
    run_op("post_flush", F_SUB, 1'b0, 1'b0, 7'h24, 64'd100, 64'd1, 64'd99);

    // Asynchronous reset with an op buffered
    alu_writeback_ready = 1'b0;
    @(negedge CLK);
    drive(F_ADD, 1'b0, 1'b0, 7'h25, 64'd1, 64'd1);
    @(negedge CLK);
    alu_execute_valid = 1'b0;
    check("mid_valid_pre", 64'(alu_writeback_valid), 64'd1);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_valid", 64'(alu_writeback_valid), 64'd0);
    check("mid_rst_ready", 64'(alu_execute_ready), 64'd1);
    @(negedge CLK);
    RST = 1'b0;
    alu_writeback_ready = 1'b1;

`ifdef ALU_PERF_CNT_EN
    // Performance counters: 3 accepts, 4 stall cycles, then async clear
    @(negedge CLK);
    check("perf_rst_ops", alu_perf_ops, 64'd0);
    alu_writeback_ready = 1'b0;
    drive(F_ADD, 1'b0, 1'b0, 7'h30, 64'd1, 64'd0);
    repeat (6) @(negedge CLK);
    alu_execute_valid = 1'b0;
    check("perf_ops2", alu_perf_ops, 64'd2);
    check("perf_stall4", alu_perf_stall, 64'd4);
    alu_writeback_ready = 1'b1;
    repeat (2) @(negedge CLK);
    alu_writeback_ready = 1'b0;
    drive(F_ADD, 1'b0, 1'b0, 7'h31, 64'd2, 64'd0);
    @(negedge CLK);
    alu_execute_valid = 1'b0;
    check("perf_ops3", alu_perf_ops, 64'd3);
    check("perf_stall_hold", alu_perf_stall, 64'd4);
    #2 RST = 1'b1;
    #1;
    check("perf_clr_ops", alu_perf_ops, 64'd0);
    check("perf_clr_stall", alu_perf_stall, 64'd0);
    check("perf_clr_valid", 64'(alu_writeback_valid), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    alu_writeback_ready = 1'b1;
`endif

    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
